// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer sequencer.
// Holds the FSM state encoding, the clog2 helper and the
// accumulator-width function.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Ceiling log2. Never returns 0, so a size-1 dimension still gets a
    // 1-bit address port.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // A sum of n products of two signed dw-bit words plus a signed dw-bit
    // bias fits in this many bits without overflow.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n);
        return 2 * dw + clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate register.
//   load    : acc <= sign-extended bias
//   acc_en  : acc <= acc + a*b (signed)
//   neither : hold
// acc_nxt_c is the combinational next value, so the parent can act on the
// final sum in the same cycle it is formed.
module fc_mac
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     acc_en,
    input  logic [DATA_W-1:0]        a,
    input  logic [DATA_W-1:0]        b,
    input  logic [DATA_W-1:0]        bias,
    output logic signed [ACC_W-1:0]  acc_nxt_c
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [2*DATA_W-1:0] prod_c;

    assign prod_c = $signed(a) * $signed(b);

    // Load has priority: it marks the first cycle of a new neuron.
    always_comb begin
        acc_nxt_c = acc_q;
        if (load) begin
            acc_nxt_c = ACC_W'($signed(bias));
        end else if (acc_en) begin
            acc_nxt_c = acc_q + ACC_W'(prod_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_nxt_c;
        end
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: for each output neuron n, reads the bias,
// streams INPUT_SIZE input/weight pairs through a signed MAC, then presents a
// ReLU-saturated result on a valid/ready port.
//   start/busy/done       : run control
//   in_addr/in_data       : input-vector buffer, 1-cycle read latency
//   w_addr/w_data         : weight buffer (n*INPUT_SIZE+j), 1-cycle latency
//   b_addr/b_data         : bias buffer (n), 1-cycle latency
//   out_valid/out_ready   : result handshake with out_idx/out_data
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int unsigned INPUT_SIZE  = 16,
    parameter int unsigned OUTPUT_SIZE = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OUT_SHIFT   = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [clog2(INPUT_SIZE)-1:0]               in_addr,
    input  logic [DATA_W-1:0]                          in_data,
    output logic [clog2(INPUT_SIZE*OUTPUT_SIZE)-1:0]   w_addr,
    input  logic [DATA_W-1:0]                          w_data,
    output logic [clog2(OUTPUT_SIZE)-1:0]              b_addr,
    input  logic [DATA_W-1:0]                          b_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [clog2(OUTPUT_SIZE)-1:0]              out_idx,
    output logic [DATA_W-1:0]                          out_data
);

    localparam int unsigned IA_W  = clog2(INPUT_SIZE);
    localparam int unsigned WA_W  = clog2(INPUT_SIZE * OUTPUT_SIZE);
    localparam int unsigned NI_W  = clog2(OUTPUT_SIZE);
    localparam int unsigned ACC_W = acc_w(DATA_W, INPUT_SIZE);

    localparam logic [IA_W-1:0]  J_LAST  = IA_W'(INPUT_SIZE - 1);
    localparam logic [NI_W-1:0]  N_LAST  = NI_W'(OUTPUT_SIZE - 1);
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'({DATA_W{1'b1}});

    state_e                  state_q, state_d;
    logic [IA_W-1:0]         j_q, j_d;
    logic [NI_W-1:0]         n_q, n_d;
    logic [WA_W-1:0]         w_addr_q, w_addr_d;
    logic [NI_W-1:0]         out_idx_q, out_idx_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic                    busy_q, done_q, out_valid_q;

    logic                    mac_load_c;
    logic                    mac_acc_en_c;
    logic signed [ACC_W-1:0] acc_nxt_c;
    logic signed [ACC_W-1:0] shifted_c;
    logic [DATA_W-1:0]       sat_c;

    fc_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mac_load_c),
        .acc_en    (mac_acc_en_c),
        .a         (in_data),
        .b         (w_data),
        .bias      (b_data),
        .acc_nxt_c (acc_nxt_c)
    );

    // ReLU, arithmetic shift, then clamp to the unsigned output range.
    always_comb begin
        sat_c     = '0;
        shifted_c = acc_nxt_c >>> OUT_SHIFT;
        if (acc_nxt_c[ACC_W-1] || (acc_nxt_c == '0)) begin
            sat_c = '0;
        end else if ($unsigned(shifted_c) > OUT_MAX) begin
            sat_c = '1;
        end else begin
            sat_c = shifted_c[DATA_W-1:0];
        end
    end

    // Next-state and datapath control. The final product lands in DRAIN,
    // so the result is captured from the MAC's next value on leaving DRAIN.
    always_comb begin
        state_d      = state_q;
        j_d          = j_q;
        n_d          = n_q;
        w_addr_d     = w_addr_q;
        out_idx_d    = out_idx_q;
        out_data_d   = out_data_q;
        mac_load_c   = 1'b0;
        mac_acc_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BIAS;
                    n_d     = '0;
                    j_d     = '0;
                end
            end
            ST_BIAS: begin
                state_d  = ST_MAC;
                j_d      = '0;
                w_addr_d = WA_W'(n_q * INPUT_SIZE);
            end
            ST_MAC: begin
                // Bias data arrives during j=0; products trail addresses by one.
                mac_load_c   = (j_q == '0);
                mac_acc_en_c = (j_q != '0);
                if (j_q == J_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    j_d      = j_q + 1'b1;
                    w_addr_d = w_addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                mac_acc_en_c = 1'b1;
                state_d      = ST_OUT;
                out_idx_d    = n_q;
                out_data_d   = sat_c;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (n_q == N_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = ST_BIAS;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            j_q         <= '0;
            n_q         <= '0;
            w_addr_q    <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            n_q         <= n_d;
            w_addr_q    <= w_addr_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            out_valid_q <= (state_d == ST_OUT);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign in_addr   = j_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = n_q;

endmodule
